// File: rtl/mem_arbiter.sv
// Core/debug arbiter for the unified memory; hides the fixed read
// latency behind a req/gnt/rvalid handshake.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wd,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  output logic          busy
);

  if (LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: LAT must be at least 1");
  end

  localparam int CW = $clog2(LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          id;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wd;
  logic          pick;

  // 1 selects debug: sole requester wins, a tie goes to the port not served last
  always_comb begin
    pick = d_req & (~c_req | ~last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      id       <= 1'b0;
      we       <= 1'b0;
      adr      <= '0;
      wd       <= '0;
      rdata    <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (c_req | d_req) begin
            id    <= pick;
            last  <= pick;
            we    <= pick ? d_we  : c_we;
            adr   <= pick ? d_adr : c_adr;
            wd    <= pick ? d_wd  : c_wd;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (we) begin
            state <= IDLE;
          end else begin
            cnt   <= CW'(LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rdata    <= m_rd;
            c_rvalid <= ~id;
            d_rvalid <= id;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_en  = (state == ISSUE);
  assign m_we  = m_en & we;
  assign m_adr = adr;
  assign m_wd  = wd;
  assign c_gnt = m_en & ~id;
  assign d_gnt = m_en & id;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on LAT=2/1/4 builds plus a
// randomized two-requester run checked against a transaction model.
module tb_mem_arbiter;

  localparam int LAT0 = 2;

  logic clk;
  logic reset;
  logic c_req, c_we, d_req, d_we;
  logic [31:0] c_adr, c_wd, d_adr, d_wd;
  logic [2:0] cgnt, dgnt, crv, drv, men, mwe, bsy;
  logic [2:0][31:0] madr, mwd, rdat;
  logic [31:0] ref_mem [16];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input logic [3:0] i);
    return (i == 4'd4) ? 32'hE3A00005 : {16'hC0DE, 12'h000, i};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 4;
    logic [31:0] mrd;
    logic [31:0] mem [16];
    logic [31:0] pipe [L];

    mem_arbiter #(.AW(32), .DW(32), .LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
      .c_gnt(cgnt[k]), .c_rvalid(crv[k]),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wd(d_wd),
      .d_gnt(dgnt[k]), .d_rvalid(drv[k]),
      .rdata(rdat[k]),
      .m_en(men[k]), .m_we(mwe[k]), .m_adr(madr[k]), .m_wd(mwd[k]),
      .m_rd(mrd), .busy(bsy[k])
    );

    // memory: read data appears L edges after the edge that samples m_en
    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(4'(i));
        for (int i = 0; i < L; i++) pipe[i] <= '0;
      end else begin
        if (men[k] && mwe[k]) mem[madr[k][5:2]] <= mwd[k];
        pipe[0] <= (men[k] && !mwe[k]) ? mem[madr[k][5:2]] : 32'h0BAD0BAD;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mrd = pipe[L-1];
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    c_adr = 0; d_adr = 0; c_wd = 0; d_wd = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(4'(i));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    c_req = 1; d_req = 1; c_adr = 32'h10; d_adr = 32'h20;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      checks++; if ({cgnt, dgnt, crv, drv, men, mwe, bsy} !== 21'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {cgnt, dgnt, crv, drv, men, mwe, bsy}); end
      checks++; if ({madr, mwd, rdat} !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", {madr, mwd, rdat}); end
    end
    do_reset();
  endtask

  task automatic test_core_read();
    do_reset();
    c_req = 1; c_we = 0; c_adr = 32'h10;
    @(negedge clk);
    checks++; if (cgnt[0] !== 1'b1) begin errors++; $display("FAIL crd_gnt: got %b want 1", cgnt[0]); end
    checks++; if (dgnt[0] !== 1'b0) begin errors++; $display("FAIL crd_dgnt: got %b want 0", dgnt[0]); end
    checks++; if ({men[0], mwe[0]} !== 2'b10) begin errors++; $display("FAIL crd_men: got %b want 10", {men[0], mwe[0]}); end
    checks++; if (madr[0] !== 32'h10) begin errors++; $display("FAIL crd_madr: got %h want 10", madr[0]); end
    c_req = 0;
    for (int t = 2; t <= 5; t++) begin
      @(negedge clk);
      checks++; if (crv[0] !== (t == 4)) begin errors++; $display("FAIL crd_rvalid T%0d: got %b want %b", t, crv[0], t == 4); end
      checks++; if ({drv[0], dgnt[0], men[0]} !== 3'b0) begin errors++; $display("FAIL crd_quiet T%0d: got %b want 000", t, {drv[0], dgnt[0], men[0]}); end
      checks++; if (bsy[0] !== (t < 4)) begin errors++; $display("FAIL crd_busy T%0d: got %b want %b", t, bsy[0], t < 4); end
      if (t >= 4) begin
        checks++; if (rdat[0] !== 32'hE3A00005) begin errors++; $display("FAIL crd_rdata T%0d: got %h want e3a00005", t, rdat[0]); end
      end
    end
  endtask

  task automatic test_debug_write();
    do_reset();
    d_req = 1; d_we = 1; d_adr = 32'h40; d_wd = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({dgnt[0], cgnt[0]} !== 2'b10) begin errors++; $display("FAIL dwr_gnt: got %b want 10", {dgnt[0], cgnt[0]}); end
    checks++; if ({men[0], mwe[0]} !== 2'b11) begin errors++; $display("FAIL dwr_men: got %b want 11", {men[0], mwe[0]}); end
    checks++; if ({madr[0], mwd[0]} !== {32'h40, 32'hDEADBEEF}) begin errors++; $display("FAIL dwr_bus: got %h want 00000040deadbeef", {madr[0], mwd[0]}); end
    d_req = 0; d_we = 0;
    @(negedge clk);
    checks++; if ({bsy[0], men[0], mwe[0]} !== 3'b0) begin errors++; $display("FAIL dwr_idle: got %b want 000", {bsy[0], men[0], mwe[0]}); end
    checks++; if ({crv[0], drv[0]} !== 2'b0) begin errors++; $display("FAIL dwr_norv: got %b want 00", {crv[0], drv[0]}); end
    // read the word back through the same port
    d_req = 1; d_we = 0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      if (t == 1) d_req = 0;
      checks++; if (drv[0] !== (t == LAT0 + 2)) begin errors++; $display("FAIL dwr_rb_rv t%0d: got %b want %b", t, drv[0], t == LAT0 + 2); end
      if (t == LAT0 + 2) begin
        checks++; if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL dwr_rb_data: got %h want deadbeef", rdat[0]); end
      end
    end
  endtask

  task automatic test_alternate();
    int p, m;
    bit eg, port, erv;
    p = LAT0 + 2;
    do_reset();
    c_req = 1; c_we = 0; c_adr = 32'h10;
    d_req = 1; d_we = 0; d_adr = 32'h20;
    for (int n = 1; n <= 4 * p; n++) begin
      @(negedge clk);
      eg = ((n - 1) % p == 0);
      port = ((n - 1) / p) % 2 == 1;
      checks++; if ({cgnt[0], dgnt[0]} !== {eg & ~port, eg & port}) begin errors++; $display("FAIL alt_gnt n%0d: got %b want %b", n, {cgnt[0], dgnt[0]}, {eg & ~port, eg & port}); end
      erv = (n % p == 0);
      m = n / p;
      port = ((m - 1) % 2) == 1;
      checks++; if ({crv[0], drv[0]} !== {erv & ~port, erv & port}) begin errors++; $display("FAIL alt_rv n%0d: got %b want %b", n, {crv[0], drv[0]}, {erv & ~port, erv & port}); end
      if (erv) begin
        checks++; if (rdat[0] !== init_word(port ? 4'd8 : 4'd4)) begin errors++; $display("FAIL alt_rdata n%0d: got %h want %h", n, rdat[0], init_word(port ? 4'd8 : 4'd4)); end
      end
    end
    c_req = 0; d_req = 0;
    repeat (p) @(negedge clk);
  endtask

  task automatic test_latency();
    int busy_n [3];
    do_reset();
    for (int k = 0; k < 3; k++) busy_n[k] = 0;
    c_req = 1; c_we = 0; c_adr = 32'h10;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) c_req = 0;
      for (int k = 0; k < 3; k++) begin
        if (bsy[k]) busy_n[k]++;
        checks++; if (crv[k] !== (n == lat_of(k) + 2)) begin errors++; $display("FAIL lat%0d_rv n%0d: got %b want %b", lat_of(k), n, crv[k], n == lat_of(k) + 2); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy_n[k] != lat_of(k) + 1) begin errors++; $display("FAIL lat%0d_busy: got %0d want %0d", lat_of(k), busy_n[k], lat_of(k) + 1); end
      checks++; if (rdat[k] !== 32'hE3A00005) begin errors++; $display("FAIL lat%0d_rdata: got %h want e3a00005", lat_of(k), rdat[k]); end
      checks++; if ({dgnt[k], drv[k]} !== 2'b0) begin errors++; $display("FAIL lat%0d_dbg: got %b want 00", lat_of(k), {dgnt[k], drv[k]}); end
    end
  endtask

  task automatic test_reset_mid();
    c_req = 1; c_we = 0; c_adr = 32'h10;
    @(negedge clk);
    c_req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if ({cgnt[0], dgnt[0], crv[0], drv[0], men[0], mwe[0], bsy[0]} !== 7'b0) begin errors++; $display("FAIL mid_ctl: got %b want 0", {cgnt[0], dgnt[0], crv[0], drv[0], men[0], mwe[0], bsy[0]}); end
    checks++; if ({madr[0], mwd[0], rdat[0]} !== 96'b0) begin errors++; $display("FAIL mid_data: got %h want 0", {madr[0], mwd[0], rdat[0]}); end
    reset = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(4'(i));
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++; if ({crv[0], bsy[0], men[0]} !== 3'b0) begin errors++; $display("FAIL mid_quiet t%0d: got %b want 000", t, {crv[0], bsy[0], men[0]}); end
    end
    c_req = 1; c_adr = 32'h10;
    d_req = 1; d_we = 0; d_adr = 32'h20;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) c_req = 0;
      if (n == 5) d_req = 0;
      checks++; if ({cgnt[0], dgnt[0]} !== {n == 1, n == 5}) begin errors++; $display("FAIL mid_gnt n%0d: got %b want %b", n, {cgnt[0], dgnt[0]}, {n == 1, n == 5}); end
      checks++; if ({crv[0], drv[0]} !== {n == 4, n == 8}) begin errors++; $display("FAIL mid_rv n%0d: got %b want %b", n, {crv[0], drv[0]}, {n == 4, n == 8}); end
      if (n == 4 || n == 8) begin
        checks++; if (rdat[0] !== init_word(n == 4 ? 4'd4 : 4'd8)) begin errors++; $display("FAIL mid_rdata n%0d: got %h want %h", n, rdat[0], init_word(n == 4 ? 4'd4 : 4'd8)); end
      end
    end
  endtask

  task automatic test_dreq_pulse();
    int men_n;
    do_reset();
    men_n = 0;
    c_req = 1; c_we = 0; c_adr = 32'h18;
    @(negedge clk);
    checks++; if ({cgnt[0], men[0]} !== 2'b11) begin errors++; $display("FAIL pulse_cgnt: got %b want 11", {cgnt[0], men[0]}); end
    c_req = 0;
    d_req = 1; d_we = 1; d_adr = 32'h3C; d_wd = 32'h12345678;
    for (int t = 2; t <= 8; t++) begin
      @(negedge clk);
      if (t == 2) begin d_req = 0; d_we = 0; end
      if (men[0]) men_n++;
      checks++; if (dgnt[0] !== 1'b0) begin errors++; $display("FAIL pulse_dgnt T%0d: got %b want 0", t, dgnt[0]); end
      checks++; if (madr[0] !== 32'h18) begin errors++; $display("FAIL pulse_madr T%0d: got %h want 18", t, madr[0]); end
      checks++; if (crv[0] !== (t == 4)) begin errors++; $display("FAIL pulse_crv T%0d: got %b want %b", t, crv[0], t == 4); end
    end
    checks++; if (men_n != 0) begin errors++; $display("FAIL pulse_men: got %0d extra accesses want 0", men_n); end
    checks++; if (rdat[0] !== init_word(4'd6)) begin errors++; $display("FAIL pulse_rdata: got %h want %h", rdat[0], init_word(4'd6)); end
  endtask

  task automatic test_random();
    int free_at, g_cyc, rv_cyc;
    bit g_port, g_we, rv_port, last, cp, dp, w;
    logic [31:0] g_adr, g_wd, rv_data, exp_rd;
    do_reset();
    free_at = 0; g_cyc = -1; rv_cyc = -1;
    g_port = 0; g_we = 0; rv_port = 0; last = 1; cp = 0; dp = 0;
    g_adr = 0; g_wd = 0; rv_data = 0; exp_rd = 0;
    for (int n = 0; n < 600; n++) begin
      checks++; if ({cgnt[0], dgnt[0]} !== {n == g_cyc && !g_port, n == g_cyc && g_port}) begin errors++; $display("FAIL rnd_gnt n%0d: got %b", n, {cgnt[0], dgnt[0]}); end
      checks++; if (men[0] !== (n == g_cyc)) begin errors++; $display("FAIL rnd_men n%0d: got %b want %b", n, men[0], n == g_cyc); end
      checks++; if (mwe[0] !== (n == g_cyc && g_we)) begin errors++; $display("FAIL rnd_mwe n%0d: got %b want %b", n, mwe[0], n == g_cyc && g_we); end
      if (n == g_cyc) begin
        checks++; if (madr[0] !== g_adr) begin errors++; $display("FAIL rnd_madr n%0d: got %h want %h", n, madr[0], g_adr); end
        if (g_we) begin
          checks++; if (mwd[0] !== g_wd) begin errors++; $display("FAIL rnd_mwd n%0d: got %h want %h", n, mwd[0], g_wd); end
        end
      end
      checks++; if ({crv[0], drv[0]} !== {n == rv_cyc && !rv_port, n == rv_cyc && rv_port}) begin errors++; $display("FAIL rnd_rv n%0d: got %b", n, {crv[0], drv[0]}); end
      if (n == rv_cyc) exp_rd = rv_data;
      checks++; if (rdat[0] !== exp_rd) begin errors++; $display("FAIL rnd_rdata n%0d: got %h want %h", n, rdat[0], exp_rd); end
      checks++; if (bsy[0] !== (n < free_at)) begin errors++; $display("FAIL rnd_busy n%0d: got %b want %b", n, bsy[0], n < free_at); end
      if (n == g_cyc) begin
        if (g_port) dp = 0;
        else cp = 0;
      end
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1; c_we = 1'($urandom_range(0, 1));
        c_adr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; d_we = 1'($urandom_range(0, 1));
        d_adr = 32'($urandom_range(0, 15)) << 2; d_wd = $urandom;
      end
      c_req = cp; d_req = dp;
      if (n >= free_at && (cp || dp)) begin
        w = (cp && dp) ? !last : dp;
        last = w;
        g_cyc = n + 1; g_port = w;
        g_we = w ? d_we : c_we;
        g_adr = w ? d_adr : c_adr;
        g_wd = w ? d_wd : c_wd;
        if (g_we) begin
          ref_mem[g_adr[5:2]] = g_wd;
          free_at = n + 2;
        end else begin
          rv_cyc = n + 2 + LAT0; rv_port = w;
          rv_data = ref_mem[g_adr[5:2]];
          free_at = rv_cyc;
        end
      end
      @(negedge clk);
    end
    c_req = 0; d_req = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    c_adr = 0; d_adr = 0; c_wd = 0; d_wd = 0;
    test_reset();
    test_core_read();
    test_debug_write();
    test_alternate();
    test_latency();
    test_reset_mid();
    test_dreq_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
